// File: rtl/rt_chnl_deser.sv
// Per-channel serial-to-parallel deserializer with address tagging and an output FIFO.
// Optional statistics counters are enabled by defining RT_CHNL_DESER_STATS_EN.
module rt_chnl_deser #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned PAD_MIN    = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             din,
  input  logic             frame_n,
  input  logic             valid_n,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [3:0]       out_dst,
  output logic             out_sop,
  output logic             out_eop,
  output logic             out_err,
  output logic             busy,
  output logic             err_short,
  output logic             err_pad,
`ifdef RT_CHNL_DESER_STATS_EN
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] byte_count,
`endif
  output logic             err_ovf
);

  localparam int unsigned PtrW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [7:0]  PadMin = 8'(PAD_MIN);
  localparam logic [PtrW:0] Full = (PtrW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {StSync, StIdle, StAddr, StPad, StData, StDrop} state_e;

  state_e        state_q, state_d;
  logic [3:0]    addr_q, addr_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    pad_cnt_q, pad_cnt_d;
  logic [7:0]    shreg_q, shreg_d, shreg_bit;
  logic          sop_pend_q, sop_pend_d;
  logic          short_d, pad_err_d, ovf_d;
  logic          enq, enq_eop, enq_err;
  logic [7:0]    enq_byte;

  logic [14:0]   mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0] count_q, count_d;
  logic          full, deq, push;
  logic [14:0]   head;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    bit_cnt_d  = bit_cnt_q;
    pad_cnt_d  = pad_cnt_q;
    shreg_d    = shreg_q;
    sop_pend_d = sop_pend_q;
    short_d    = 1'b0;
    pad_err_d  = 1'b0;
    enq        = 1'b0;
    enq_byte   = '0;
    enq_eop    = 1'b0;
    enq_err    = 1'b0;
    shreg_bit  = shreg_q;
    shreg_bit[bit_cnt_q] = din;
    case (state_q)
      StSync: if (frame_n) state_d = StIdle;
      StIdle: begin
        if (!frame_n) begin
          addr_d    = {3'b000, din};
          bit_cnt_d = 3'd1;
          state_d   = StAddr;
        end
      end
      StAddr: begin
        if (frame_n) begin
          short_d = 1'b1;
          state_d = StIdle;
        end else begin
          addr_d[bit_cnt_q[1:0]] = din;
          if (bit_cnt_q == 3'd3) begin
            pad_cnt_d = '0;
            state_d   = StPad;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      StPad: begin
        if (frame_n) begin
          short_d = 1'b1;
          state_d = StIdle;
        end else if (!valid_n) begin
          if (pad_cnt_q >= PadMin) begin
            shreg_d    = {7'b0, din};
            bit_cnt_d  = 3'd1;
            sop_pend_d = 1'b1;
            state_d    = StData;
          end else begin
            pad_err_d = 1'b1;
            state_d   = StDrop;
          end
        end else if (pad_cnt_q != 8'hff) begin
          pad_cnt_d = pad_cnt_q + 8'd1;
        end
      end
      StData: begin
        if (!valid_n && bit_cnt_q == 3'd7) begin
          enq        = 1'b1;
          enq_byte   = shreg_bit;
          enq_eop    = frame_n;
          sop_pend_d = 1'b0;
          bit_cnt_d  = 3'd0;
          shreg_d    = '0;
          if (frame_n) state_d = StIdle;
        end else if (frame_n) begin
          // Unfilled bits are still zero because shreg is cleared at every byte start.
          enq      = 1'b1;
          enq_byte = valid_n ? shreg_q : shreg_bit;
          enq_eop  = 1'b1;
          enq_err  = 1'b1;
          short_d  = 1'b1;
          state_d  = StIdle;
        end else if (!valid_n) begin
          shreg_d   = shreg_bit;
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end
      StDrop: if (frame_n) state_d = StIdle;
      default: state_d = StSync;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StSync;
      addr_q     <= '0;
      bit_cnt_q  <= '0;
      pad_cnt_q  <= '0;
      shreg_q    <= '0;
      sop_pend_q <= 1'b0;
      err_short  <= 1'b0;
      err_pad    <= 1'b0;
      err_ovf    <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      bit_cnt_q  <= bit_cnt_d;
      pad_cnt_q  <= pad_cnt_d;
      shreg_q    <= shreg_d;
      sop_pend_q <= sop_pend_d;
      err_short  <= short_d;
      err_pad    <= pad_err_d;
      err_ovf    <= ovf_d;
    end
  end

  // SYNC counts as idle so that every output reads zero out of reset.
  assign busy = (state_q != StIdle) && (state_q != StSync);

  assign full      = (count_q == Full);
  assign out_valid = (count_q != '0);
  assign deq       = out_valid && out_ready;
  assign push      = enq && (!full || deq);
  assign ovf_d     = enq && full && !deq;

  always_comb begin
    count_d = count_q;
    if (push && !deq)      count_d = count_q + 1'b1;
    else if (!push && deq) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= {addr_q, enq_byte, sop_pend_q, enq_eop, enq_err};
  end

  assign head     = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_dst  = head[14:11];
  assign out_data = head[10:3];
  assign out_sop  = head[2];
  assign out_eop  = head[1];
  assign out_err  = head[0];

`ifdef RT_CHNL_DESER_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pkt_count  <= '0;
      byte_count <= '0;
    end else if (push && !enq_err) begin
      if (byte_count != '1)           byte_count <= byte_count + 1'b1;
      if (enq_eop && pkt_count != '1) pkt_count  <= pkt_count + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_rt_chnl_deser.sv
// Directed self-checking bench for rt_chnl_deser (default build, FIFO_DEPTH=8, PAD_MIN=5).
module tb_rt_chnl_deser;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       din = 1'b0, frame_n = 1'b1, valid_n = 1'b1, out_ready = 1'b1;
  logic       out_valid, out_sop, out_eop, out_err, busy, err_short, err_pad, err_ovf;
  logic [7:0] out_data;
  logic [3:0] out_dst;

  rt_chnl_deser #(.FIFO_DEPTH(8), .PAD_MIN(5), .CNT_W(16)) dut (
    .clock(clock), .reset(reset), .din(din), .frame_n(frame_n), .valid_n(valid_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_dst(out_dst),
    .out_sop(out_sop), .out_eop(out_eop), .out_err(out_err), .busy(busy),
    .err_short(err_short), .err_pad(err_pad), .err_ovf(err_ovf)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int fails  = 0;
  int n_short = 0, n_pad = 0, n_ovf = 0;
  logic [14:0] got_q[$];
  logic [14:0] exp_q[$];

  // Pulses and handshakes are observed mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      if (err_short) n_short++;
      if (err_pad)   n_pad++;
      if (err_ovf)   n_ovf++;
      if (out_valid && out_ready)
        got_q.push_back({out_dst, out_data, out_sop, out_eop, out_err});
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] ent(input logic [3:0] a, input logic [7:0] d,
                                      input logic s, input logic e, input logic r);
    return {a, d, s, e, r};
  endfunction

  task automatic cyc(input logic f, input logic v, input logic d);
    frame_n = f; valid_n = v; din = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0);
  endtask

  task automatic send_hdr(input logic [3:0] a, input int pad);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, a[i]);
    for (int i = 0; i < pad; i++) cyc(1'b0, 1'b1, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    for (int i = 0; i < 8; i++) cyc(last && (i == 7), 1'b0, b[i]);
  endtask

  task automatic check_got(input string tag, input int base);
    int n;
    n = got_q.size() - base;
    check_eq({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++)
      check_eq({tag, "_entry"}, 32'(got_q[base + i]), 32'(exp_q[i]));
  endtask

  initial begin
    int base, s0, p0, o0;
    logic [7:0] b;
    logic [4:0] part;

    repeat (2) @(posedge clock);
    #1;
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_errs", 32'({err_short, err_pad, err_ovf}), 32'd0);
    check_eq("rst_data", 32'({out_dst, out_data, out_sop, out_eop, out_err}), 32'd0);
    reset = 1'b0;
    idle(2);

    // 1: nominal two-byte packet with latency check on the first byte.
    base = got_q.size(); s0 = n_short; p0 = n_pad; o0 = n_ovf;
    send_hdr(4'hA, 5);
    b = 8'h3C;
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b0, b[i]);
    check_eq("t1_busy", 32'(busy), 32'd1);
    check_eq("t1_valid_before", 32'(out_valid), 32'd0);
    cyc(1'b0, 1'b0, b[7]);
    check_eq("t1_valid_after", 32'(out_valid), 32'd1);
    check_eq("t1_head_data", 32'(out_data), 32'h3C);
    send_byte(8'hA5, 1'b1);
    idle(3);
    exp_q = {ent(4'hA, 8'h3C, 1, 0, 0), ent(4'hA, 8'hA5, 0, 1, 0)};
    check_got("t1", base);
    check_eq("t1_errs", 32'((n_short - s0) + (n_pad - p0) + (n_ovf - o0)), 32'd0);

    // 2: random valid_n during address, stalls mid-byte.
    base = got_q.size(); s0 = n_short; p0 = n_pad;
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'($urandom_range(0, 1)), i[0] ? 1'b0 : 1'b1);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0);
    b = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin cyc(1'b0, 1'b1, 1'b1); cyc(1'b0, 1'b1, 1'b0); end
      cyc(i == 7, 1'b0, b[i]);
    end
    idle(3);
    exp_q = {ent(4'h5, 8'hC3, 1, 1, 0)};
    check_got("t2", base);
    check_eq("t2_errs", 32'((n_short - s0) + (n_pad - p0)), 32'd0);

    // 3: short pad, dropped frame, then a good packet.
    base = got_q.size(); p0 = n_pad;
    send_hdr(4'h6, 3);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b0);
    idle(2);
    check_eq("t3_err_pad", 32'(n_pad - p0), 32'd1);
    check_eq("t3_none", 32'(got_q.size() - base), 32'd0);
    send_hdr(4'h7, 5);
    send_byte(8'h5A, 1'b1);
    idle(3);
    exp_q = {ent(4'h7, 8'h5A, 1, 1, 0)};
    check_got("t3", base);

    // 4: frame ends after 5 bits of the second byte.
    base = got_q.size(); s0 = n_short;
    send_hdr(4'h9, 6);
    send_byte(8'h11, 1'b0);
    part = 5'b01101;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, part[i]);
    cyc(1'b1, 1'b1, 1'b0);
    idle(3);
    exp_q = {ent(4'h9, 8'h11, 1, 0, 0), ent(4'h9, 8'h0D, 0, 1, 1)};
    check_got("t4", base);
    check_eq("t4_err_short", 32'(n_short - s0), 32'd1);

    // 5: overflow with consumer stalled.
    out_ready = 1'b0;
    base = got_q.size(); o0 = n_ovf;
    send_hdr(4'h2, 5);
    for (int i = 0; i < 10; i++) send_byte(8'(i), i == 9);
    idle(3);
    check_eq("t5_err_ovf", 32'(n_ovf - o0), 32'd2);
    check_eq("t5_held_valid", 32'(out_valid), 32'd1);
    check_eq("t5_held_head", 32'({out_dst, out_data, out_sop}), 32'({4'h2, 8'h00, 1'b1}));
    out_ready = 1'b1;
    idle(12);
    exp_q = {};
    for (int i = 0; i < 8; i++) exp_q.push_back(ent(4'h2, 8'(i), i == 0, 0, 0));
    check_got("t5", base);
    check_eq("t5_empty", 32'(out_valid), 32'd0);

    // 6: reset mid-DATA, rest of frame ignored.
    out_ready = 1'b0;
    send_hdr(4'h4, 5);
    send_byte(8'h77, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1);
    check_eq("t6_pre_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("t6_rst_valid", 32'(out_valid), 32'd0);
    check_eq("t6_rst_busy", 32'(busy), 32'd0);
    check_eq("t6_rst_data", 32'(out_data), 32'd0);
    cyc(1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    s0 = n_short; p0 = n_pad;
    base = got_q.size();
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, i[0]);
    cyc(1'b1, 1'b0, 1'b1);
    out_ready = 1'b1;
    idle(3);
    check_eq("t6_ignored", 32'(got_q.size() - base), 32'd0);
    send_hdr(4'h3, 5);
    send_byte(8'h81, 1'b1);
    idle(3);
    exp_q = {ent(4'h3, 8'h81, 1, 1, 0)};
    check_got("t6", base);
    check_eq("t6_errs", 32'((n_short - s0) + (n_pad - p0)), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
